// File: rtl/mnist_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mnist_frame_sequencer_if
// Description : Bundles the pixel-in, CNN-side and result-out handshakes of
//               the MNIST frame sequencer.
//               slave  : the sequencer itself.
//               master : the environment (pixel source, CNN, result sink).
// Signals     : pix_valid/pix_data/pix_ready       upstream pixel handshake
//               cnn_rst/cnn_data/cnn_max/
//               cnn_data_valid                     drive the CNN inputs
//               cnn_valid_out/cnn_decision         CNN classification
//               result_valid/result_class/
//               result_timeout/result_ready        downstream result handshake
//               busy                               sequencer not in LOAD
// Revision    : 1.0 - initial release
// ============================================================================
interface mnist_frame_sequencer_if;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic        pix_ready;
  logic        cnn_rst;
  logic [31:0] cnn_data;
  logic [31:0] cnn_max;
  logic        cnn_data_valid;
  logic        cnn_valid_out;
  logic [3:0]  cnn_decision;
  logic        result_valid;
  logic [3:0]  result_class;
  logic        result_timeout;
  logic        result_ready;
  logic        busy;

  modport slave (
    input  pix_valid, pix_data, cnn_valid_out, cnn_decision, result_ready,
    output pix_ready, cnn_rst, cnn_data, cnn_max, cnn_data_valid,
           result_valid, result_class, result_timeout, busy
  );

  modport master (
    output pix_valid, pix_data, cnn_valid_out, cnn_decision, result_ready,
    input  pix_ready, cnn_rst, cnn_data, cnn_max, cnn_data_valid,
           result_valid, result_class, result_timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/mnist_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mnist_frame_sequencer
// Description : Buffers one frame of 32-bit float pixels, tracks the frame
//               maximum while loading, then resets the CNN, streams the frame
//               into it one pixel per cycle with the maximum held constant,
//               waits (with timeout) for the classification and returns it
//               over a valid/ready handshake.
// Ports       : clk     - single clock, rising edge
//               rst     - synchronous active-high reset
//               io_bus  - slave side of mnist_frame_sequencer_if
// Revision    : 1.0 - initial release
// ============================================================================
module mnist_frame_sequencer #(
  parameter int NUM_PIX     = 784,
  parameter int ADDR_BIT    = 10,
  parameter int RST_CYCLES  = 2,
  parameter int TIMEOUT     = 20000,
  parameter int TIMEOUT_BIT = 15
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  mnist_frame_sequencer_if.slave     io_bus
);

  localparam int c_PRIME_BIT = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [ADDR_BIT-1:0]    c_LAST_ADDR  = ADDR_BIT'(NUM_PIX - 1);
  localparam logic [c_PRIME_BIT-1:0] c_LAST_PRIME = c_PRIME_BIT'(RST_CYCLES - 1);
  localparam logic [TIMEOUT_BIT-1:0] c_LAST_TMO   = TIMEOUT_BIT'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_PRIME  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t                 r_state;
  logic [ADDR_BIT-1:0]    r_wr_cnt;
  logic [ADDR_BIT-1:0]    r_rd_cnt;
  logic [c_PRIME_BIT-1:0] r_prime_cnt;
  logic [TIMEOUT_BIT-1:0] r_tmo_cnt;
  logic [31:0]            r_max;
  logic [31:0]            r_mem [NUM_PIX];

  logic        r_pix_ready;
  logic        r_cnn_rst;
  logic [31:0] r_cnn_data;
  logic [31:0] r_cnn_max;
  logic        r_cnn_data_valid;
  logic        r_result_valid;
  logic [3:0]  r_result_class;
  logic        r_result_timeout;
  logic        r_busy;

  logic                w_accept;
  logic                w_max_upd;
  logic [31:0]         w_max_next;
  logic [ADDR_BIT-1:0] w_rd_addr;

  assign w_accept   = r_pix_ready && io_bus.pix_valid;
  // Negative pixels never win; magnitudes of non-negative floats order like
  // unsigned integers, so an integer compare on bits 30:0 is sufficient.
  assign w_max_upd  = !io_bus.pix_data[31] && (io_bus.pix_data[30:0] > r_max[30:0]);
  assign w_max_next = w_max_upd ? io_bus.pix_data : r_max;
  // Pixel 0 is fetched during the last PRIME cycle so the RAM latency is
  // hidden; in STREAM the fetch runs one address ahead of the shown pixel.
  assign w_rd_addr  = (r_state == S_STREAM) ? (r_rd_cnt + 1'b1) : '0;

  // Frame buffer: deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_cnt] <= io_bus.pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_LOAD;
      r_wr_cnt         <= '0;
      r_rd_cnt         <= '0;
      r_prime_cnt      <= '0;
      r_tmo_cnt        <= '0;
      r_max            <= '0;
      r_pix_ready      <= 1'b0;
      r_cnn_rst        <= 1'b1;
      r_cnn_data       <= '0;
      r_cnn_max        <= '0;
      r_cnn_data_valid <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_class   <= '0;
      r_result_timeout <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_pix_ready <= 1'b1;
          r_cnn_rst   <= 1'b0;
          r_busy      <= 1'b0;
          if (w_accept) begin
            r_max <= w_max_next;
            if (r_wr_cnt == c_LAST_ADDR) begin
              r_wr_cnt    <= '0;
              r_prime_cnt <= '0;
              r_state     <= S_PRIME;
              r_pix_ready <= 1'b0;
              r_cnn_rst   <= 1'b1;
              r_cnn_max   <= w_max_next;
              r_busy      <= 1'b1;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end

        S_PRIME: begin
          if (r_prime_cnt == c_LAST_PRIME) begin
            r_state          <= S_STREAM;
            r_cnn_rst        <= 1'b0;
            r_cnn_data       <= r_mem[w_rd_addr];
            r_cnn_data_valid <= 1'b1;
            r_rd_cnt         <= '0;
          end else begin
            r_prime_cnt <= r_prime_cnt + 1'b1;
          end
        end

        S_STREAM: begin
          if (r_rd_cnt == c_LAST_ADDR) begin
            r_state          <= S_WAIT;
            r_cnn_data       <= '0;
            r_cnn_data_valid <= 1'b0;
            r_rd_cnt         <= '0;
            r_tmo_cnt        <= '0;
          end else begin
            r_cnn_data <= r_mem[w_rd_addr];
            r_rd_cnt   <= w_rd_addr;
          end
        end

        S_WAIT: begin
          // A CNN answer on the final timeout cycle still counts as an answer.
          if (io_bus.cnn_valid_out) begin
            r_state          <= S_RESULT;
            r_result_class   <= io_bus.cnn_decision;
            r_result_timeout <= 1'b0;
            r_result_valid   <= 1'b1;
          end else if (r_tmo_cnt == c_LAST_TMO) begin
            r_state          <= S_RESULT;
            r_result_class   <= 4'hF;
            r_result_timeout <= 1'b1;
            r_result_valid   <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        S_RESULT: begin
          if (io_bus.result_ready) begin
            r_state        <= S_LOAD;
            r_result_valid <= 1'b0;
            r_max          <= '0;
            r_tmo_cnt      <= '0;
            r_cnn_max      <= '0;
            r_busy         <= 1'b0;
            r_pix_ready    <= 1'b1;
          end
        end

        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign io_bus.pix_ready      = r_pix_ready;
  assign io_bus.cnn_rst        = r_cnn_rst;
  assign io_bus.cnn_data       = r_cnn_data;
  assign io_bus.cnn_max        = r_cnn_max;
  assign io_bus.cnn_data_valid = r_cnn_data_valid;
  assign io_bus.result_valid   = r_result_valid;
  assign io_bus.result_class   = r_result_class;
  assign io_bus.result_timeout = r_result_timeout;
  assign io_bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mnist_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mnist_frame_sequencer
// Description : Self-checking bench for mnist_frame_sequencer. A timeline
//               model (frame contents, completion cycle, result cycle) gives
//               the expected outputs of every cycle; literal checks pin key
//               values of the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mnist_frame_sequencer;

  localparam int NUM_PIX     = 784;
  localparam int ADDR_BIT    = 10;
  localparam int RST_CYCLES  = 2;
  localparam int TIMEOUT     = 450;
  localparam int TIMEOUT_BIT = 15;

  localparam int M_RST  = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mnist_frame_sequencer_if bus ();

  mnist_frame_sequencer #(
    .NUM_PIX    (NUM_PIX),
    .ADDR_BIT   (ADDR_BIT),
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT),
    .TIMEOUT_BIT(TIMEOUT_BIT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: frame contents plus the cycle numbers at which each phase starts.
  int          cyc = 0;
  int          m_mode = M_RST;
  int          m_nacc = 0;
  int          t_prime = 0, t_stream = 0, t_wait = 0, t_res = 0;
  bit          m_have_res = 1'b0;
  logic [31:0] frame [NUM_PIX];
  logic [31:0] gen   [NUM_PIX];
  logic [31:0] m_max = '0;
  logic [3:0]  m_class = '0;
  bit          m_tmo = 1'b0;

  function automatic logic [31:0] frame_max();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NUM_PIX; i++)
      if (!frame[i][31] && frame[i][30:0] > m[30:0]) m = frame[i];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // Model advance: classify what happened in the cycle that just ended.
  always @(posedge clk) begin
    if (rst) begin
      m_mode     = M_RST;
      m_have_res = 1'b0;
    end else begin
      case (m_mode)
        M_RST: begin
          m_mode = M_LOAD;
          m_nacc = 0;
        end
        M_LOAD: begin
          if (bus.pix_valid) begin
            frame[m_nacc] = bus.pix_data;
            m_nacc++;
            if (m_nacc == NUM_PIX) begin
              m_mode     = M_RUN;
              t_prime    = cyc + 1;
              t_stream   = t_prime + RST_CYCLES;
              t_wait     = t_stream + NUM_PIX;
              m_max      = frame_max();
              m_have_res = 1'b0;
            end
          end
        end
        default: begin
          if (!m_have_res) begin
            if (cyc >= t_wait) begin
              if (bus.cnn_valid_out) begin
                m_have_res = 1'b1; t_res = cyc + 1;
                m_class = bus.cnn_decision; m_tmo = 1'b0;
              end else if (cyc - t_wait == TIMEOUT - 1) begin
                m_have_res = 1'b1; t_res = cyc + 1;
                m_class = 4'hF; m_tmo = 1'b1;
              end
            end
          end else if (bus.result_ready) begin
            m_mode     = M_LOAD;
            m_nacc     = 0;
            m_have_res = 1'b0;
          end
        end
      endcase
    end
    cyc++;
  end

  // Compare process: expected outputs of the current cycle from the model.
  logic [31:0] e_data;
  logic        e_dv, e_rv;
  always @(negedge clk) begin
    if (cyc > 0) begin
      case (m_mode)
        M_RST: begin
          chk("pix_ready", bus.pix_ready, 0);
          chk("cnn_rst", bus.cnn_rst, 1);
          chk("cnn_data", bus.cnn_data, 0);
          chk("cnn_max", bus.cnn_max, 0);
          chk("cnn_data_valid", bus.cnn_data_valid, 0);
          chk("result_valid", bus.result_valid, 0);
          chk("result_class", bus.result_class, 0);
          chk("result_timeout", bus.result_timeout, 0);
          chk("busy", bus.busy, 0);
        end
        M_LOAD: begin
          chk("pix_ready", bus.pix_ready, 1);
          chk("cnn_rst", bus.cnn_rst, 0);
          chk("cnn_data", bus.cnn_data, 0);
          chk("cnn_data_valid", bus.cnn_data_valid, 0);
          chk("result_valid", bus.result_valid, 0);
          chk("busy", bus.busy, 0);
        end
        default: begin
          e_dv   = (cyc >= t_stream) && (cyc < t_wait);
          e_data = e_dv ? frame[cyc - t_stream] : 32'h0;
          e_rv   = m_have_res && (cyc >= t_res);
          chk("pix_ready", bus.pix_ready, 0);
          chk("busy", bus.busy, 1);
          chk("cnn_rst", bus.cnn_rst, {31'h0, cyc < t_stream});
          chk("cnn_data_valid", bus.cnn_data_valid, {31'h0, e_dv});
          chk("cnn_data", bus.cnn_data, e_data);
          chk("result_valid", bus.result_valid, {31'h0, e_rv});
          if (!e_rv) chk("cnn_max", bus.cnn_max, m_max);
          if (e_rv) begin
            chk("result_class", bus.result_class, {28'h0, m_class});
            chk("result_timeout", bus.result_timeout, {31'h0, m_tmo});
          end
        end
      endcase
    end
  end

  task automatic wait_until_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        n_err++;
        $display("FAIL wait_cycle timeout target=%0d now=%0d", c, cyc);
        finish_now();
      end
    end
  endtask

  task automatic load_frame(input int pct);
    int  idx, guard;
    bit  v;
    idx = 0; guard = 0;
    while (idx < NUM_PIX) begin
      @(negedge clk);
      v = ($urandom_range(99) < pct);
      bus.pix_valid = v;
      bus.pix_data  = v ? gen[idx] : $urandom;
      if (v && bus.pix_ready) idx++;
      guard++;
      if (guard > 20 * NUM_PIX) begin
        n_err++;
        $display("FAIL load_frame stalled accepted=%0d expected=%0d", idx, NUM_PIX);
        finish_now();
      end
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  // CNN stand-in: one valid_out pulse 'delay' cycles after WAIT entry.
  task automatic respond(input int delay, input logic [3:0] dec);
    wait_until_cyc(t_wait + delay);
    bus.cnn_valid_out = 1'b1;
    bus.cnn_decision  = dec;
    @(negedge clk);
    bus.cnn_valid_out = 1'b0;
    bus.cnn_decision  = 4'($urandom);
  endtask

  task automatic handshake(input int hold, input logic [3:0] ecls, input logic etmo);
    int guard;
    guard = 0;
    while (bus.result_valid !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 2 * TIMEOUT) begin
        n_err++;
        $display("FAIL result_valid never rose got=%b expected=1", bus.result_valid);
        finish_now();
      end
    end
    chk("lit_result_class", bus.result_class, {28'h0, ecls});
    chk("lit_result_timeout", bus.result_timeout, {31'h0, etmo});
    repeat (hold) begin
      @(negedge clk);
      chk("lit_rv_held", bus.result_valid, 1);
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk("lit_rv_drop", bus.result_valid, 0);
    chk("lit_pix_ready_back", bus.pix_ready, 1);
  endtask

  logic [3:0] d4;

  initial begin
    bus.pix_valid     = 1'b0;
    bus.pix_data      = '0;
    bus.cnn_valid_out = 1'b0;
    bus.cnn_decision  = '0;
    bus.result_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Frame 1: ramp with 1.0 at index 300; decision 7 after 400 WAIT cycles.
    for (int i = 0; i < NUM_PIX; i++) gen[i] = 32'(i) << 13;
    gen[300] = 32'h3F800000;
    load_frame(100);
    wait_until_cyc(t_prime);
    chk("lit_f1_cnn_max", bus.cnn_max, 32'h3F800000);
    chk("lit_f1_cnn_rst", bus.cnn_rst, 1);
    wait_until_cyc(t_stream);
    chk("lit_f1_rst_low", bus.cnn_rst, 0);
    chk("lit_f1_first_valid", bus.cnn_data_valid, 1);
    wait_until_cyc(t_stream + 300);
    chk("lit_f1_pix300", bus.cnn_data, 32'h3F800000);
    respond(400, 4'd7);
    handshake(5, 4'd7, 1'b0);

    // Frame 2: random data, 50% valid, no answer -> timeout, ready held early.
    for (int i = 0; i < NUM_PIX; i++) gen[i] = $urandom;
    load_frame(50);
    bus.result_ready = 1'b1;
    wait_until_cyc(t_wait + TIMEOUT - 1);
    chk("lit_tmo_not_yet", bus.result_valid, 0);
    @(negedge clk);
    chk("lit_tmo_valid", bus.result_valid, 1);
    chk("lit_tmo_class", bus.result_class, 32'hF);
    chk("lit_tmo_flag", bus.result_timeout, 1);
    @(negedge clk);
    chk("lit_tmo_drop", bus.result_valid, 0);
    bus.result_ready = 1'b0;

    // Frame 3: all zero; answer exactly on the last timeout cycle.
    for (int i = 0; i < NUM_PIX; i++) gen[i] = 32'h0;
    load_frame(70);
    wait_until_cyc(t_prime);
    chk("lit_zero_max", bus.cnn_max, 32'h0);
    respond(TIMEOUT - 1, 4'd3);
    handshake(0, 4'd3, 1'b0);

    // Frame 4: negatives (-100.0, all-ones) and 0.5 as the true maximum.
    for (int i = 0; i < NUM_PIX; i++)
      gen[i] = (i % 7 == 0) ? 32'hC2C80000 : ($urandom & 32'h3EFFFFFF);
    gen[13]  = 32'hFFFFFFFF;
    gen[500] = 32'h3F000000;
    load_frame(60);
    wait_until_cyc(t_prime);
    chk("lit_neg_max", bus.cnn_max, 32'h3F000000);
    wait_until_cyc(t_stream + 100);
    bus.cnn_valid_out = 1'b1;   // must be ignored while streaming
    @(negedge clk);
    bus.cnn_valid_out = 1'b0;
    d4 = 4'($urandom_range(9));
    respond($urandom_range(300, 10), d4);
    handshake(2, d4, 1'b0);

    // Frame 5: large maximum, then reset in the middle of streaming.
    for (int i = 0; i < NUM_PIX; i++) gen[i] = $urandom;
    gen[10] = 32'h7F000000;
    load_frame(100);
    wait_until_cyc(t_stream + 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit_rst_cnn_rst", bus.cnn_rst, 1);
    chk("lit_rst_pix_ready", bus.pix_ready, 0);
    chk("lit_rst_valid", bus.cnn_data_valid, 0);
    chk("lit_rst_max", bus.cnn_max, 0);

    // Frame 6: small values; the old maximum must not leak in.
    for (int i = 0; i < NUM_PIX; i++) gen[i] = $urandom & 32'h0FFFFFFF;
    load_frame(80);
    wait_until_cyc(t_prime);
    chk("lit_f6_max_small", {31'h0, bus.cnn_max < 32'h10000000}, 1);
    respond(5, 4'd9);
    handshake(0, 4'd9, 1'b0);

    repeat (3) @(negedge clk);
    finish_now();
  end

endmodule
`default_nettype wire
